// File: rtl/mc_main_control_if.sv
// Control bundle between mc_main_control and the multi-cycle datapath.
// master = controller (drives enables), slave = datapath (drives op/zero).
interface mc_main_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic             zero;
    logic             pcen;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic             zext;
    logic [1:0]       pcsource;
    logic             aluop3;
    logic             aluop2;
    logic             aluop1;
    logic             aluop0;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;
    logic             illegal;

    modport master (
        input  op, zero,
        output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop3, aluop2, aluop1, aluop0,
               instr_done, instr_cnt, illegal
    );

    modport slave (
        output op, zero,
        input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop3, aluop2, aluop1, aluop0,
               instr_done, instr_cnt, illegal
    );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS-lite main control FSM with retired-instruction counter and sticky illegal flag.
// Optional feature macro: MC_JUMP_EN enables the j (op 000010) instruction.
module mc_main_control #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    mc_main_control_if.master  io_bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIX  = 4'd9,
        S_ANDIX  = 4'd10,
        S_ORIX   = 4'd11,
        S_IWB    = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_illegal;

    logic       w_pcen;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_zext;
    logic [1:0] w_pcsource;
    logic [3:0] w_aluop;
    logic       w_instr_done;
    logic       w_illegal_op;

    // State register; async reset lands in FETCH so outputs show fetch controls during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore control decode; zero only gates pcen in BEQ.
    always_comb begin
        w_next       = S_FETCH;
        w_pcen       = 1'b0;
        w_iord       = 1'b0;
        w_memread    = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_zext       = 1'b0;
        w_pcsource   = 2'b00;
        w_aluop      = 4'b0000;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_irwrite = 1'b1;
                w_alusrcb = 2'b01;
                w_pcen    = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (io_bus.op)
                    OP_RTYPE:      w_next = S_REX;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BEQ;
                    OP_ADDI:       w_next = S_ADDIX;
                    OP_ANDI:       w_next = S_ANDIX;
                    OP_ORI:        w_next = S_ORIX;
`ifdef MC_JUMP_EN
                    OP_J:          w_next = S_JUMP;
`endif
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                if (io_bus.op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_MEMRD;
                end
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_memtoreg   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_memwrite   = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_REX: begin
                w_alusrca = 1'b1;
                w_aluop   = 4'b0001;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca    = 1'b1;
                w_aluop      = 4'b0010;
                w_pcsource   = 2'b01;
                w_pcen       = io_bus.zero;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDIX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_IWB;
            end
            S_ANDIX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_zext    = 1'b1;
                w_aluop   = 4'b0100;
                w_next    = S_IWB;
            end
            S_ORIX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_zext    = 1'b1;
                w_aluop   = 4'b1000;
                w_next    = S_IWB;
            end
            S_IWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                w_pcsource   = 2'b10;
                w_pcen       = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_cnt <= '0;
        end else if (w_instr_done) begin
            r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_cnt <= r_instr_cnt;
        end
    end

    // Sticky illegal-opcode flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_op) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    assign io_bus.pcen       = w_pcen;
    assign io_bus.iord       = w_iord;
    assign io_bus.memread    = w_memread;
    assign io_bus.memwrite   = w_memwrite;
    assign io_bus.irwrite    = w_irwrite;
    assign io_bus.memtoreg   = w_memtoreg;
    assign io_bus.regdst     = w_regdst;
    assign io_bus.regwrite   = w_regwrite;
    assign io_bus.alusrca    = w_alusrca;
    assign io_bus.alusrcb    = w_alusrcb;
    assign io_bus.zext       = w_zext;
    assign io_bus.pcsource   = w_pcsource;
    assign io_bus.aluop3     = w_aluop[3];
    assign io_bus.aluop2     = w_aluop[2];
    assign io_bus.aluop1     = w_aluop[1];
    assign io_bus.aluop0     = w_aluop[0];
    assign io_bus.instr_done = w_instr_done;
    assign io_bus.instr_cnt  = r_instr_cnt;
    assign io_bus.illegal    = r_illegal;

endmodule
